// File: rtl/mpc_mul_share_arb.sv
// Round-robin sharing of one pipelined signed multiplier among N_REQ requesters.
// Optional macro MPC_MUL_ARB_SAT_EN: saturate the delivered product to RES_W instead of wrapping.

module mpc_mul_share_lane #(
   parameter int A_W   = 21,
   parameter int B_W   = 10,
   parameter int TAG_W = 2,
   parameter int IDX   = 0
) (
   input  logic             grant,
   input  logic             ce,
   input  logic             flush,
   input  logic             reset,
   input  logic             last_vld,
   input  logic [TAG_W-1:0] last_tag,
   input  logic [A_W-1:0]   a,
   input  logic [B_W-1:0]   b,
   output logic             ready,
   output logic [A_W-1:0]   ga,
   output logic [B_W-1:0]   gb,
   output logic             rvalid
);
   assign ready  = ce & ~flush & ~reset & grant;
   assign ga     = grant ? a : '0;
   assign gb     = grant ? b : '0;
   assign rvalid = ce & last_vld & (last_tag == TAG_W'(IDX));
endmodule

module mpc_mul_share_arb #(
   parameter int N_REQ = 4,
   parameter int A_W   = 21,
   parameter int B_W   = 10,
   parameter int P_W   = 31,
   parameter int LAT   = 4,
   parameter int RES_W = 24
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       ce,
   input  logic                       flush,
   input  logic [N_REQ-1:0]           req_valid,
   output logic [N_REQ-1:0]           req_ready,
   input  logic [N_REQ*A_W-1:0]       req_a,
   input  logic [N_REQ*B_W-1:0]       req_b,
   output logic [A_W-1:0]             mul_a,
   output logic [B_W-1:0]             mul_b,
   output logic                       mul_ce,
   input  logic [P_W-1:0]             mul_p,
   output logic [N_REQ-1:0]           res_valid,
   output logic [RES_W-1:0]           res_data,
   output logic [$clog2(N_REQ)-1:0]   res_tag,
   output logic                       busy
);
   localparam int TAG_W = $clog2(N_REQ);

   logic [TAG_W-1:0]                  ptr, gidx, ptr_nxt, jj;
   logic [N_REQ-1:0]                  grant;
   logic                              found, xfer;
   int                                j;
   logic [N_REQ-1:0][A_W-1:0]         ga;
   logic [N_REQ-1:0][B_W-1:0]         gb;
   logic [LAT-1:0]                    vld_pipe;
   logic [LAT-1:0][TAG_W-1:0]         tag_pipe;

   // First valid requester at or after ptr, wrapping modulo N_REQ.
   always_comb begin
      grant = '0;
      gidx  = '0;
      found = 1'b0;
      j     = 0;
      jj    = '0;
      for (int k = 0; k < N_REQ; k++) begin
         j = int'(ptr) + k;
         if (j >= N_REQ) j = j - N_REQ;
         jj = TAG_W'(j);
         if (!found && req_valid[jj]) begin
            found     = 1'b1;
            grant[jj] = 1'b1;
            gidx      = jj;
         end
      end
   end

   for (genvar g = 0; g < N_REQ; g++) begin : g_lane
      mpc_mul_share_lane #(.A_W(A_W), .B_W(B_W), .TAG_W(TAG_W), .IDX(g)) u_lane (
         .grant    (grant[g]),
         .ce       (ce),
         .flush    (flush),
         .reset    (reset),
         .last_vld (vld_pipe[LAT-1]),
         .last_tag (tag_pipe[LAT-1]),
         .a        (req_a[g*A_W +: A_W]),
         .b        (req_b[g*B_W +: B_W]),
         .ready    (req_ready[g]),
         .ga       (ga[g]),
         .gb       (gb[g]),
         .rvalid   (res_valid[g])
      );
   end

   // Non-granted lanes drive zero, so an OR tree is the operand mux.
   always_comb begin
      mul_a = '0;
      mul_b = '0;
      for (int i = 0; i < N_REQ; i++) begin
         mul_a = mul_a | ga[i];
         mul_b = mul_b | gb[i];
      end
   end

   assign mul_ce  = ce;
   assign xfer    = |(req_valid & req_ready);
   assign ptr_nxt = (gidx == TAG_W'(N_REQ-1)) ? '0 : gidx + 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr      <= '0;
         vld_pipe <= '0;
         tag_pipe <= '0;
      end else begin
         if (xfer) ptr <= ptr_nxt;
         if (ce) begin
            tag_pipe[0] <= gidx;
            for (int s = 1; s < LAT; s++) tag_pipe[s] <= tag_pipe[s-1];
         end
         // Flush masks whatever the multiplier still holds; tags become don't-care.
         if (flush) begin
            vld_pipe <= '0;
         end else if (ce) begin
            vld_pipe[0] <= xfer;
            for (int s = 1; s < LAT; s++) vld_pipe[s] <= vld_pipe[s-1];
         end
      end
   end

   assign res_tag = tag_pipe[LAT-1];
   assign busy    = |vld_pipe;

`ifdef MPC_MUL_ARB_SAT_EN
   logic [P_W-RES_W:0] hi;
   logic               ovf;
   assign hi       = mul_p[P_W-1:RES_W-1];
   assign ovf      = ~((&hi) | ~(|hi));
   assign res_data = ovf ? {mul_p[P_W-1], {(RES_W-1){~mul_p[P_W-1]}}} : mul_p[RES_W-1:0];
`else
   assign res_data = mul_p[RES_W-1:0];
   if (RES_W < P_W) begin : g_wrap
      logic unused_hi;
      assign unused_hi = ^mul_p[P_W-1:RES_W];
   end
`endif

endmodule

// File: tb/tb_mpc_mul_share_arb.sv
// Directed bench for mpc_mul_share_arb with a behavioural LAT-deep multiplier.
module tb_mpc_mul_share_arb;
   localparam int N     = 4;
   localparam int A_W   = 21;
   localparam int B_W   = 10;
   localparam int P_W   = 31;
   localparam int LAT   = 4;
   localparam int RES_W = 24;

   logic                 clk = 1'b0;
   logic                 reset, ce, flush;
   logic [N-1:0]         req_valid, req_ready, res_valid;
   logic [N*A_W-1:0]     req_a;
   logic [N*B_W-1:0]     req_b;
   logic [A_W-1:0]       mul_a;
   logic [B_W-1:0]       mul_b;
   logic                 mul_ce, busy;
   logic [P_W-1:0]       mul_p;
   logic [RES_W-1:0]     res_data;
   logic [1:0]           res_tag;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mpc_mul_share_arb #(.N_REQ(N), .A_W(A_W), .B_W(B_W), .P_W(P_W), .LAT(LAT), .RES_W(RES_W)) dut (
      .clk(clk), .reset(reset), .ce(ce), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
      .mul_a(mul_a), .mul_b(mul_b), .mul_ce(mul_ce), .mul_p(mul_p),
      .res_valid(res_valid), .res_data(res_data), .res_tag(res_tag), .busy(busy)
   );

   // Multiplier model: product appears LAT ce-enabled edges after operands.
   logic [LAT-1:0][P_W-1:0] pm;
   always @(posedge clk) begin
      if (mul_ce) begin
         pm[0] <= P_W'($signed(mul_a) * $signed(mul_b));
         for (int s = 1; s < LAT; s++) pm[s] <= pm[s-1];
      end
   end
   assign mul_p = pm[LAT-1];

   typedef struct {
      int               idx;
      logic [A_W-1:0]   a;
      logic [B_W-1:0]   b;
      logic [RES_W-1:0] exp;
   } vec_t;

   vec_t tbl[8];
   logic [A_W-1:0]   ca[4];
   logic [B_W-1:0]   cb[4];
   logic [RES_W-1:0] cexp[4];

   function automatic vec_t mk(int idx, int a, int b, int e);
      vec_t v;
      v.idx = idx; v.a = A_W'(a); v.b = B_W'(b); v.exp = RES_W'(e);
      return v;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(int i, logic [A_W-1:0] a, logic [B_W-1:0] b);
      req_a[i*A_W +: A_W] = a;
      req_b[i*B_W +: B_W] = b;
   endtask

   task automatic do_reset();
      reset = 1'b1; flush = 1'b0; ce = 1'b1; req_valid = '0;
      step(); step();
      reset = 1'b0;
   endtask

   initial begin
      tbl[0] = mk(2, 1000, -3, -3000);
      tbl[1] = mk(0, 7, 5, 35);
      tbl[2] = mk(1, -20, -30, 600);
      tbl[3] = mk(3, 12345, -1, -12345);
      tbl[4] = mk(2, -1048576, 1, -1048576);
`ifdef MPC_MUL_ARB_SAT_EN
      tbl[5] = mk(1, -1048576, -512, 8388607);
      tbl[6] = mk(0, 1048575, 511, 8388607);
      tbl[7] = mk(3, -1048576, 511, -8388608);
`else
      tbl[5] = mk(1, -1048576, -512, 0);
      tbl[6] = mk(0, 1048575, 511, -1049087);
      tbl[7] = mk(3, -1048576, 511, 1048576);
`endif
      ca[0] = A_W'(3);   cb[0] = B_W'(2);  cexp[0] = RES_W'(6);
      ca[1] = A_W'(-5);  cb[1] = B_W'(4);  cexp[1] = RES_W'(-20);
      ca[2] = A_W'(100); cb[2] = B_W'(-6); cexp[2] = RES_W'(-600);
      ca[3] = A_W'(-7);  cb[3] = B_W'(-8); cexp[3] = RES_W'(56);

      req_a = '0; req_b = '0;
      reset = 1'b1; ce = 1'b1; flush = 1'b0; req_valid = '1;
      step(); step();
      chk("reset_ready", 64'(req_ready), 64'(0));
      chk("reset_res_valid", 64'(res_valid), 64'(0));
      chk("reset_busy", 64'(busy), 64'(0));
      reset = 1'b0;
      #1;
      chk("post_reset_grant0", 64'(req_ready), 64'(4'b0001));
      req_valid = '0;

      // Single operations from the table.
      for (int t = 0; t < 8; t++) begin
         set_op(tbl[t].idx, tbl[t].a, tbl[t].b);
         req_valid[tbl[t].idx] = 1'b1;
         #1;
         chk("single_ready", 64'(req_ready), 64'(1) << tbl[t].idx);
         step();
         req_valid = '0;
         for (int c = 0; c < LAT-1; c++) begin
            chk("single_wait_rv", 64'(res_valid), 64'(0));
            chk("single_wait_busy", 64'(busy), 64'(1));
            step();
         end
         chk("single_rv", 64'(res_valid), 64'(1) << tbl[t].idx);
         chk("single_tag", 64'(res_tag), 64'(tbl[t].idx));
         chk("single_data", 64'(res_data), 64'(tbl[t].exp));
         chk("single_busy", 64'(busy), 64'(1));
         step();
         chk("single_idle_busy", 64'(busy), 64'(0));
         chk("single_idle_rv", 64'(res_valid), 64'(0));
      end

      // Contention: strict rotation, results back-to-back in grant order.
      do_reset();
      for (int i = 0; i < N; i++) set_op(i, ca[i], cb[i]);
      req_valid = '1;
      #1;
      for (int t = 0; t < 13; t++) begin
         if (t == 8) begin req_valid = '0; #1; end
         chk("cont_ready", 64'(req_ready), (t < 8) ? (64'(1) << (t % 4)) : 64'(0));
         if (t >= LAT && t < LAT + 8) begin
            chk("cont_rv", 64'(res_valid), 64'(1) << ((t - LAT) % 4));
            chk("cont_tag", 64'(res_tag), 64'((t - LAT) % 4));
            chk("cont_data", 64'(res_data), 64'(cexp[(t - LAT) % 4]));
         end else begin
            chk("cont_rv_idle", 64'(res_valid), 64'(0));
         end
         step();
      end

      // Stall: ce low for 3 cycles after two enabled edges.
      do_reset();
      set_op(1, A_W'(7), B_W'(5));
      req_valid[1] = 1'b1;
      #1;
      chk("stall_ready", 64'(req_ready), 64'(4'b0010));
      step();
      req_valid = '0;
      step();
      ce = 1'b0;
      req_valid[0] = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("stall_no_ready", 64'(req_ready), 64'(0));
         chk("stall_no_rv", 64'(res_valid), 64'(0));
         chk("stall_busy", 64'(busy), 64'(1));
         step();
      end
      ce = 1'b1;
      req_valid = '0;
      #1;
      chk("stall_rv_early", 64'(res_valid), 64'(0));
      step();
      chk("stall_rv_early2", 64'(res_valid), 64'(0));
      step();
      chk("stall_rv", 64'(res_valid), 64'(4'b0010));
      chk("stall_data", 64'(res_data), 64'(RES_W'(35)));
      step();

      // Flush with three ops in flight; ptr must hold.
      do_reset();
      for (int i = 0; i < N; i++) set_op(i, ca[i], cb[i]);
      req_valid = '1;
      step(); step(); step();
      flush = 1'b1;
      #1;
      chk("flush_ready", 64'(req_ready), 64'(0));
      step();
      flush = 1'b0;
      req_valid = '0;
      #1;
      chk("flush_busy", 64'(busy), 64'(0));
      for (int c = 0; c < LAT + 2; c++) begin
         chk("flush_no_rv", 64'(res_valid), 64'(0));
         step();
      end
      req_valid = '1;
      #1;
      chk("flush_ptr_hold", 64'(req_ready), 64'(4'b1000));

      // Same abort via reset; ptr returns to 0.
      step(); step(); step();
      reset = 1'b1;
      #1;
      chk("rst_mid_ready", 64'(req_ready), 64'(0));
      step();
      reset = 1'b0;
      req_valid = '0;
      #1;
      chk("rst_mid_busy", 64'(busy), 64'(0));
      for (int c = 0; c < LAT + 2; c++) begin
         chk("rst_mid_no_rv", 64'(res_valid), 64'(0));
         step();
      end
      req_valid = '1;
      #1;
      chk("rst_mid_ptr0", 64'(req_ready), 64'(4'b0001));
      req_valid = '0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
